// File: rtl/boot_loader.sv
// Purpose: serial boot loader; receives LEN/payload/CHK frames and writes the payload into processor memory.
// Latency: a payload byte accepted on edge k is written (mem_we pulse) in the cycle after edge k; cpu_rst rises the cycle after a good CHK.
// Backpressure: rx_ready is a registered decode of the next state (high only in LEN/DATA/CHK); rx_valid never reaches it combinationally.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-low reset
//   start      level; in IDLE/RUN/ERR begins a new load, ignored while busy
//   rx_data    incoming byte
//   rx_valid   rx_data valid this cycle (transfer = rx_valid & rx_ready)
//   rx_ready   loader can accept a byte
//   mem_we     single-cycle write strobe per payload byte
//   mem_addr   write address (holds last value between writes)
//   mem_wdata  write data (holds last value between writes)
//   cpu_rst    active-low core reset; high only in RUN
//   busy       high in LEN, DATA and CHK
//   done       high in RUN
//   err        high in ERR
module boot_loader (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_rst,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CHK  = 3'd3;
  localparam logic [2:0] ST_RUN  = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  logic [2:0] state_q,     state_d;
  logic [7:0] cnt_q,       cnt_d;
  logic [7:0] rem_q,       rem_d;
  logic [7:0] sum_q,       sum_d;
  logic       mem_we_q,    mem_we_d;
  logic [7:0] mem_addr_q,  mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic       rx_ready_q,  rx_ready_d;
  logic       cpu_rst_q,   cpu_rst_d;
  logic       busy_q,      busy_d;
  logic       done_q,      done_d;
  logic       err_q,       err_d;

  logic       rx_acc;
  logic [7:0] chk_sum;

  // A byte only moves when the registered ready meets a valid; every
  // state/counter update below is gated on this, so idle rx cycles are inert.
  assign rx_acc  = rx_valid & rx_ready_q;
  assign chk_sum = sum_q + rx_data;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    sum_d       = sum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start) begin
          state_d = ST_LEN;
          cnt_d   = 8'h00;
          sum_d   = 8'h00;
          rem_d   = 8'h00;
        end
      end
      ST_LEN: begin
        if (rx_acc) begin
          if (rx_data == 8'h00) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
            rem_d   = rx_data;
          end
        end
      end
      ST_DATA: begin
        if (rx_acc) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q;
          mem_wdata_d = rx_data;
          // With at most 255 bytes the counter tops out at 0xFF after the
          // last write to 0xFE, so it cannot wrap inside a frame.
          cnt_d       = cnt_q + 8'd1;
          sum_d       = sum_q + rx_data;
          rem_d       = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (rx_acc) begin
          state_d = (chk_sum == 8'h00) ? ST_RUN : ST_ERR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs are flops loaded from the next-state decode, so they are
  // aligned with state_q while carrying no combinational path to the pins.
  always_comb begin
    rx_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CHK);
    busy_d     = rx_ready_d;
    done_d     = (state_d == ST_RUN);
    err_d      = (state_d == ST_ERR);
    cpu_rst_d  = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'h00;
      rem_q       <= 8'h00;
      sum_q       <= 8'h00;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 8'h00;
      mem_wdata_q <= 8'h00;
      rx_ready_q  <= 1'b0;
      cpu_rst_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      sum_q       <= sum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rx_ready_q  <= rx_ready_d;
      cpu_rst_q   <= cpu_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst   = cpu_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Purpose: self-checking bench for boot_loader; frame-level reference model plus directed and random frames.
// Latency: inputs driven and outputs sampled on the falling edge, half a cycle away from the active edge.
// Backpressure: the byte driver holds rx_valid until it sees rx_ready, bounded by a cycle budget.
module tb_boot_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_rst;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [15:0] got_q[$];   // {addr, data} of every observed write
  logic [15:0] exp_q[$];   // model writes for the current frame
  logic [7:0]  tx_q[$];    // bytes of the current frame
  logic [7:0]  tb_mem[256];
  bit   [7:0]  model_mem[256];
  bit          model_vld[256];

  boot_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Memory-side observer: records every strobe as the processor memory would see it.
  always @(negedge clk) begin
    if (mem_we) begin
      got_q.push_back({mem_addr, mem_wdata});
      tb_mem[mem_addr] = mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err}, 32'h0);
  endtask

  // Reference model: the whole frame's effect from the frame rules alone.
  task automatic model_frame(output bit ok);
    int n;
    int s;
    exp_q = {};
    n = int'(tx_q[0]);
    s = 0;
    ok = 1'b0;
    if (n == 0) return;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({8'(i), tx_q[1 + i]});
      s = s + int'(tx_q[1 + i]);
      model_mem[i] = tx_q[1 + i];
      model_vld[i] = 1'b1;
    end
    ok = ((s + int'(tx_q[n + 1])) % 256) == 0;
  endtask

  task automatic build_frame(input int n, input bit good);
    int s;
    int c;
    tx_q = {};
    tx_q.push_back(8'(n));
    if (n == 0) return;
    s = 0;
    for (int i = 0; i < n; i++) begin
      tx_q.push_back(8'($urandom_range(0, 255)));
      s = s + int'(tx_q[i + 1]);
    end
    c = (256 - (s % 256)) % 256;
    if (!good) c = (c + $urandom_range(1, 255)) % 256;
    tx_q.push_back(8'(c));
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_enters_len", {busy, rx_ready, err, done, cpu_rst}, 5'b11000);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rx_ready_wait", rx_ready, 1);
    chk("busy_core_held", {busy, cpu_rst}, 2'b10);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic run_frame(input string name, input int gap_fixed, input bit rand_gap,
                           input bit start_in_data);
    int base;
    int g;
    int nw;
    bit ok;
    base = got_q.size();
    model_frame(ok);
    do_start();
    for (int k = 0; k < tx_q.size(); k++) begin
      g = rand_gap ? $urandom_range(0, 3) : ((k >= 1) ? gap_fixed : 0);
      if (start_in_data && k == 2) start = 1'b1;
      send_byte(tx_q[k], g);
      start = 1'b0;
    end
    chk({name, "_result"}, {done, err, cpu_rst, busy, rx_ready}, ok ? 5'b10100 : 5'b01000);
    chk({name, "_no_we_after"}, mem_we, 0);
    nw = got_q.size() - base;
    chk({name, "_write_count"}, nw, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < nw; i++)
      chk({name, "_write"}, got_q[base + i], exp_q[i]);
    @(negedge clk);
    chk({name, "_hold"}, {done, err, cpu_rst, busy, mem_we}, ok ? 5'b10100 : 5'b01000);
  endtask

  initial begin
    int base;
    // Reset held for three cycles; outputs must be at reset values the whole time.
    #2 rst = 1'b0;
    #1 chk_reset_outputs("reset_async");
    repeat (3) begin
      @(negedge clk);
      chk_reset_outputs("reset_hold");
    end
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("idle_after_reset");

    tx_q = {8'h03, 8'h02, 8'h10, 8'h20, 8'hCE};
    run_frame("good", 0, 1'b0, 1'b0);

    tx_q = {8'h03, 8'h02, 8'h10, 8'h20, 8'h00};
    run_frame("badchk", 0, 1'b0, 1'b0);

    tx_q = {8'h00};
    run_frame("zerolen", 0, 1'b0, 1'b0);

    tx_q = {8'h03, 8'h02, 8'h10, 8'h20, 8'hCE};
    run_frame("gapped", 4, 1'b0, 1'b0);

    tx_q = {8'h03, 8'h02, 8'h10, 8'h20, 8'hCE};
    run_frame("start_busy", 1, 1'b0, 1'b1);

    // Reset lands right after the second payload write of a 3-byte frame.
    base = got_q.size();
    do_start();
    send_byte(8'h03, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    model_mem[0] = 8'hAA; model_vld[0] = 1'b1;
    model_mem[1] = 8'h55; model_vld[1] = 1'b1;
    #2 rst = 1'b0;
    #1 chk_reset_outputs("midframe_reset_async");
    chk("midframe_writes", got_q.size() - base, 2);
    @(negedge clk);
    chk_reset_outputs("midframe_reset_held");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("midframe_idle_wait");
    tx_q = {8'h01, 8'h7F, 8'h81};
    run_frame("after_reset", 0, 1'b0, 1'b0);

    for (int f = 0; f < 12; f++) begin
      build_frame(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12),
                  bit'($urandom_range(0, 1)));
      run_frame("random", 0, 1'b1, 1'b0);
    end

    // Maximum length frame: last write must land on 0xFE.
    build_frame(255, 1'b1);
    run_frame("maxlen", 0, 1'b0, 1'b0);
    chk("maxlen_last_addr", got_q[got_q.size() - 1][15:8], 8'hFE);

    // Writes from aborted/bad frames stay; final contents match the model.
    for (int a = 0; a < 256; a++)
      if (model_vld[a]) chk("mem_contents", tb_mem[a], model_mem[a]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
